// File: rtl/decode_ctrl_pipe.sv
// Decode controller: combinational RISC-V decode into an ID/EX control register, plus a MUL/DIV busy FSM that stalls the front end.
// Optional CSR decode for opcode 1110011 is enabled by defining CSR_DECODE_EN.
module decode_ctrl_pipe #(
    parameter int ALUCTRL_W  = 4,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid_d,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 stall_in,
    input  logic                 flush_in,
    output logic                 valid_e,
    output logic                 reg_write_e,
    output logic                 mem_write_e,
    output logic                 alu_src_e,
    output logic                 alu_a_pc_e,
    output logic                 branch_e,
    output logic [2:0]           branch_type_e,
    output logic [1:0]           jump_e,
    output logic [1:0]           result_src_e,
    output logic [2:0]           imm_src_e,
    output logic [ALUCTRL_W-1:0] alu_ctrl_e,
    output logic                 mdu_en_e,
    output logic [2:0]           mdu_op_e,
    output logic                 illegal_e,
    output logic                 stall_req
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`ifdef CSR_DECODE_EN
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       alu_a_pc;
        logic       branch;
        logic [2:0] branch_type;
        logic [1:0] jump;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [3:0] alu_ctrl;
        logic       mdu_en;
        logic [2:0] mdu_op;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    ctrl_t            dec;
    ctrl_t            bundle_q, bundle_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_load;
    logic             bad;

    function automatic logic [3:0] alu_of(input logic [2:0] f3);
        logic [3:0] r;
        case (f3)
            3'b000:  r = ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    // Every rd-writing instruction (ALU, jumps, lui/auipc, CSR) sets reg_write.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        bad       = 1'b0;
        case (op)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = 3'b001;
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: dec.alu_ctrl = alu_of(funct3);
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec.alu_ctrl = ALU_SUB;
                        else if (funct3 == 3'b101) dec.alu_ctrl = ALU_SRA;
                        else                       bad = 1'b1;
                    end
                    7'b0000001: begin
                        dec.mdu_en = 1'b1;
                        dec.mdu_op = funct3;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_of(funct3);
                if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
                    bad = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000)      dec.alu_ctrl = ALU_SRA;
                    else if (funct7 != 7'b0000000) bad = 1'b1;
                end
            end
            OP_BRANCH: begin
                dec.branch      = 1'b1;
                dec.branch_type = funct3;
                dec.alu_ctrl    = ALU_SUB;
                dec.imm_src     = 3'b010;
                if (funct3 == 3'b010 || funct3 == 3'b011) bad = 1'b1;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 2'b01;
                dec.result_src = 2'b10;
                dec.imm_src    = 3'b011;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 2'b10;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = 3'b100;
                dec.alu_ctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_a_pc  = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = 3'b100;
            end
`ifdef CSR_DECODE_EN
            OP_SYSTEM: begin
                // funct3=000 (ecall/ebreak/mret) is legal but needs no datapath controls.
                if (funct3 == 3'b100) begin
                    bad = 1'b1;
                end else if (funct3 != 3'b000) begin
                    dec.reg_write  = 1'b1;
                    dec.result_src = 2'b11;
                    dec.alu_src    = funct3[2];
                    dec.alu_ctrl   = ALU_PASSB;
                end
            end
`endif
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end
    end

    assign stall_req = (state_q == S_BUSY);
    assign cnt_load  = funct3[2] ? DIV_LOAD : MUL_LOAD;

    always_comb begin
        bundle_d = bundle_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (flush_in) begin
            bundle_d = '0;
        end else if (!stall_in && !stall_req) begin
            bundle_d = instr_valid_d ? dec : '0;
        end

        if (flush_in) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!stall_in && instr_valid_d && dec.mdu_en) begin
                        cnt_d = cnt_load;
                        if (cnt_load != '0) state_d = S_BUSY;
                    end
                end
                default: begin
                    // Leave BUSY on the edge where the count reaches zero.
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bundle_q <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
        end else begin
            bundle_q <= bundle_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_e       = bundle_q.valid;
    assign reg_write_e   = bundle_q.reg_write;
    assign mem_write_e   = bundle_q.mem_write;
    assign alu_src_e     = bundle_q.alu_src;
    assign alu_a_pc_e    = bundle_q.alu_a_pc;
    assign branch_e      = bundle_q.branch;
    assign branch_type_e = bundle_q.branch_type;
    assign jump_e        = bundle_q.jump;
    assign result_src_e  = bundle_q.result_src;
    assign imm_src_e     = bundle_q.imm_src;
    assign alu_ctrl_e    = ALUCTRL_W'(bundle_q.alu_ctrl);
    assign mdu_en_e      = bundle_q.mdu_en;
    assign mdu_op_e      = bundle_q.mdu_op;
    assign illegal_e     = bundle_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Table-driven decode checks plus directed sequences for the MUL/DIV busy FSM, flush, stall and reset.
module tb_decode_ctrl_pipe;
    localparam int ALUCTRL_W  = 4;
    localparam int MUL_CYCLES = 2;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;

    logic clk = 1'b0;
    logic reset, instr_valid_d, stall_in, flush_in;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    logic valid_e, reg_write_e, mem_write_e, alu_src_e, alu_a_pc_e, branch_e;
    logic [2:0] branch_type_e, imm_src_e, mdu_op_e;
    logic [1:0] jump_e, result_src_e;
    logic [ALUCTRL_W-1:0] alu_ctrl_e;
    logic mdu_en_e, illegal_e, stall_req;

    always #5 clk = ~clk;

    decode_ctrl_pipe #(
        .ALUCTRL_W(ALUCTRL_W), .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .instr_valid_d(instr_valid_d),
        .op(op), .funct3(funct3), .funct7(funct7),
        .stall_in(stall_in), .flush_in(flush_in),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .alu_src_e(alu_src_e), .alu_a_pc_e(alu_a_pc_e), .branch_e(branch_e),
        .branch_type_e(branch_type_e), .jump_e(jump_e), .result_src_e(result_src_e),
        .imm_src_e(imm_src_e), .alu_ctrl_e(alu_ctrl_e), .mdu_en_e(mdu_en_e),
        .mdu_op_e(mdu_op_e), .illegal_e(illegal_e), .stall_req(stall_req)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [8*12-1:0] name;
        logic            vld;
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [23:0]     exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("ok   %s got=%h", name, got);
        end
    endtask

    // {rw,mw,alu_src,a_pc,branch,btype,jump,result,imm,alu,mdu_en,mdu_op,illegal}
    function automatic logic [23:0] mk(input logic rw, input logic mw, input logic as,
                                       input logic apc, input logic br, input logic [2:0] bt,
                                       input logic [1:0] j, input logic [1:0] rs,
                                       input logic [2:0] is, input logic [3:0] alu,
                                       input logic mdu, input logic [2:0] mop, input logic ill);
        return {rw, mw, as, apc, br, bt, j, rs, is, alu, mdu, mop, ill};
    endfunction

    function automatic logic [23:0] act();
        return {reg_write_e, mem_write_e, alu_src_e, alu_a_pc_e, branch_e, branch_type_e,
                jump_e, result_src_e, imm_src_e, alu_ctrl_e[3:0], mdu_en_e, mdu_op_e, illegal_e};
    endfunction

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        instr_valid_d = v;
        op            = o;
        funct3        = f3;
        funct7        = f7;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] R = 7'b0110011;
    logic [23:0] ILL, ADD_E, SUB_E, DIV_E, MUL_E, LUI_E;
    int n;
    int guard;
    logic held_bad;

    initial begin
        ILL   = mk(0,0,0,0,0,3'd0,2'd0,2'd0,3'd0,4'd0,0,3'd0,1);
        ADD_E = mk(1,0,0,0,0,3'd0,2'd0,2'd0,3'd0,4'd0,0,3'd0,0);
        SUB_E = mk(1,0,0,0,0,3'd0,2'd0,2'd0,3'd0,4'd1,0,3'd0,0);
        DIV_E = mk(1,0,0,0,0,3'd0,2'd0,2'd0,3'd0,4'd0,1,3'd4,0);
        MUL_E = mk(1,0,0,0,0,3'd0,2'd0,2'd0,3'd0,4'd0,1,3'd0,0);
        LUI_E = mk(1,0,1,0,0,3'd0,2'd0,2'd0,3'd4,4'd10,0,3'd0,0);

        vecs.push_back('{"load",    1, 7'b0000011, 3'b010, 7'h00, mk(1,0,1,0,0,3'd0,2'd0,2'd1,3'd0,4'd0,0,3'd0,0)});
        vecs.push_back('{"store",   1, 7'b0100011, 3'b010, 7'h00, mk(0,1,1,0,0,3'd0,2'd0,2'd0,3'd1,4'd0,0,3'd0,0)});
        vecs.push_back('{"add",     1, R,          3'b000, 7'h00, ADD_E});
        vecs.push_back('{"sub",     1, R,          3'b000, 7'h20, SUB_E});
        vecs.push_back('{"sra",     1, R,          3'b101, 7'h20, mk(1,0,0,0,0,3'd0,2'd0,2'd0,3'd0,4'd9,0,3'd0,0)});
        vecs.push_back('{"sltu",    1, R,          3'b011, 7'h00, mk(1,0,0,0,0,3'd0,2'd0,2'd0,3'd0,4'd6,0,3'd0,0)});
        vecs.push_back('{"and",     1, R,          3'b111, 7'h00, mk(1,0,0,0,0,3'd0,2'd0,2'd0,3'd0,4'd2,0,3'd0,0)});
        vecs.push_back('{"r_ill_f3",1, R,          3'b001, 7'h20, ILL});
        vecs.push_back('{"r_ill_f7",1, R,          3'b000, 7'h02, ILL});
        vecs.push_back('{"xori",    1, 7'b0010011, 3'b100, 7'h55, mk(1,0,1,0,0,3'd0,2'd0,2'd0,3'd0,4'd4,0,3'd0,0)});
        vecs.push_back('{"srai",    1, 7'b0010011, 3'b101, 7'h20, mk(1,0,1,0,0,3'd0,2'd0,2'd0,3'd0,4'd9,0,3'd0,0)});
        vecs.push_back('{"srli",    1, 7'b0010011, 3'b101, 7'h00, mk(1,0,1,0,0,3'd0,2'd0,2'd0,3'd0,4'd8,0,3'd0,0)});
        vecs.push_back('{"slli_ill",1, 7'b0010011, 3'b001, 7'h01, ILL});
        vecs.push_back('{"addi_f7", 1, 7'b0010011, 3'b000, 7'h20, mk(1,0,1,0,0,3'd0,2'd0,2'd0,3'd0,4'd0,0,3'd0,0)});
        vecs.push_back('{"beq",     1, 7'b1100011, 3'b000, 7'h00, mk(0,0,0,0,1,3'd0,2'd0,2'd0,3'd2,4'd1,0,3'd0,0)});
        vecs.push_back('{"bgeu",    1, 7'b1100011, 3'b111, 7'h00, mk(0,0,0,0,1,3'd7,2'd0,2'd0,3'd2,4'd1,0,3'd0,0)});
        vecs.push_back('{"br_ill",  1, 7'b1100011, 3'b010, 7'h00, ILL});
        vecs.push_back('{"jal",     1, 7'b1101111, 3'b000, 7'h00, mk(1,0,0,0,0,3'd0,2'd1,2'd2,3'd3,4'd0,0,3'd0,0)});
        vecs.push_back('{"jalr",    1, 7'b1100111, 3'b000, 7'h00, mk(1,0,1,0,0,3'd0,2'd2,2'd2,3'd0,4'd0,0,3'd0,0)});
        vecs.push_back('{"lui",     1, 7'b0110111, 3'b000, 7'h00, LUI_E});
        vecs.push_back('{"auipc",   1, 7'b0010111, 3'b000, 7'h00, mk(1,0,1,1,0,3'd0,2'd0,2'd0,3'd4,4'd0,0,3'd0,0)});
        vecs.push_back('{"unknown", 1, 7'b1111111, 3'b000, 7'h00, ILL});
`ifdef CSR_DECODE_EN
        vecs.push_back('{"csrrw",   1, 7'b1110011, 3'b001, 7'h00, mk(1,0,0,0,0,3'd0,2'd0,2'd3,3'd0,4'd10,0,3'd0,0)});
        vecs.push_back('{"ecall",   1, 7'b1110011, 3'b000, 7'h00, 24'h0});
        vecs.push_back('{"csr_f3_4",1, 7'b1110011, 3'b100, 7'h00, ILL});
`else
        vecs.push_back('{"csrrw",   1, 7'b1110011, 3'b001, 7'h00, ILL});
        vecs.push_back('{"ecall",   1, 7'b1110011, 3'b000, 7'h00, ILL});
`endif
        vecs.push_back('{"bubble",  0, R,          3'b000, 7'h00, 24'h0});

        reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        drive(1, R, 3'b000, 7'h00);
        step(); step();
        chk("reset_valid", 32'(valid_e), 32'd0);
        chk("reset_bundle", 32'(act()), 32'd0);
        chk("reset_stall", 32'(stall_req), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].op, vecs[i].f3, vecs[i].f7);
            step();
            chk($sformatf("%0s_valid", vecs[i].name), 32'(valid_e), 32'(vecs[i].vld));
            chk($sformatf("%0s_bundle", vecs[i].name), 32'(act()), 32'(vecs[i].exp));
            chk($sformatf("%0s_stall", vecs[i].name), 32'(stall_req), 32'd0);
        end

        // Divide: 31 busy cycles, bundle held, next op loads after stall drops.
        drive(1, R, 3'b100, 7'h01);
        step();
        chk("div_load", 32'(act()), 32'(DIV_E));
        drive(1, R, 3'b000, 7'h00);
        n = 0; guard = 0; held_bad = 1'b0;
        while (stall_req === 1'b1 && guard < 60) begin
            n++; guard++;
            if (act() !== DIV_E || valid_e !== 1'b1) held_bad = 1'b1;
            step();
        end
        chk("div_stall_cycles", 32'(n), 32'd31);
        chk("div_held", 32'(held_bad), 32'd0);
        chk("div_hold_last", 32'(act()), 32'(DIV_E));
        step();
        chk("add_after_div", 32'(act()), 32'(ADD_E));
        chk("add_after_div_stall", 32'(stall_req), 32'd0);

        // Mul with stall_in raised during busy: counter still runs, one busy cycle.
        drive(1, R, 3'b000, 7'h01);
        step();
        chk("mul_load", 32'(act()), 32'(MUL_E));
        stall_in = 1'b1;
        drive(1, R, 3'b000, 7'h20);
        n = 0; guard = 0;
        while (stall_req === 1'b1 && guard < 10) begin
            n++; guard++;
            step();
        end
        chk("mul_stall_cycles", 32'(n), 32'd1);
        chk("mul_hold_stall_in", 32'(act()), 32'(MUL_E));
        stall_in = 1'b0;
        step();
        chk("sub_after_mul", 32'(act()), 32'(SUB_E));

        // stall_in hold in IDLE
        drive(1, R, 3'b000, 7'h00);
        step();
        stall_in = 1'b1;
        drive(1, 7'b0110111, 3'b000, 7'h00);
        step();
        chk("stall_hold", 32'(act()), 32'(ADD_E));
        stall_in = 1'b0;
        step();
        chk("stall_release", 32'(act()), 32'(LUI_E));

        // Flush beats stall and a valid load.
        flush_in = 1'b1; stall_in = 1'b1;
        drive(1, R, 3'b000, 7'h20);
        step();
        chk("flush_prio_valid", 32'(valid_e), 32'd0);
        chk("flush_prio_bundle", 32'(act()), 32'd0);
        flush_in = 1'b0; stall_in = 1'b0;

        // Flush in the 5th cycle of a divide.
        drive(1, R, 3'b101, 7'h01);
        step();
        drive(1, R, 3'b000, 7'h00);
        step(); step(); step();
        chk("flushdiv_busy", 32'(stall_req), 32'd1);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        chk("flushdiv_stall", 32'(stall_req), 32'd0);
        chk("flushdiv_valid", 32'(valid_e), 32'd0);
        chk("flushdiv_bundle", 32'(act()), 32'd0);
        step();
        chk("flushdiv_next", 32'(act()), 32'(ADD_E));
        chk("flushdiv_next_stall", 32'(stall_req), 32'd0);

        // Reset three cycles into a divide.
        drive(1, R, 3'b110, 7'h01);
        step();
        drive(1, R, 3'b000, 7'h00);
        step(); step(); step();
        reset = 1'b1;
        step();
        chk("rstdiv_stall", 32'(stall_req), 32'd0);
        chk("rstdiv_valid", 32'(valid_e), 32'd0);
        chk("rstdiv_bundle", 32'(act()), 32'd0);
        reset = 1'b0;
        step();
        chk("rstdiv_add_valid", 32'(valid_e), 32'd1);
        chk("rstdiv_add", 32'(act()), 32'(ADD_E));
        chk("rstdiv_add_stall", 32'(stall_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
Next-generation decode controller for the 5-stage RISC-V core. It decodes op/funct3/funct7 into a wider control bundle with 4+ bit ALU control, M-extension, illegal-instruction and optional CSR support. It registers the bundle into the ID/EX boundary with stall/flush handling. It runs a multi-cycle MUL/DIV busy FSM that back-pressures the front end.

Parameters:
ALUCTRL_W, 4, width of alu_ctrl_e (must be >=4; upper bits zero-filled)
MUL_CYCLES, 2, execute cycles for funct3[2]=0 M-ops (>=1)
DIV_CYCLES, 32, execute cycles for funct3[2]=1 M-ops (>=1)
CNT_W, 6, busy counter width (must hold max(MUL_CYCLES,DIV_CYCLES)-1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
instr_valid_d  in  1  decode-stage instruction valid
op  in  7  opcode
funct3  in  3  funct3
funct7  in  7  funct7
stall_in  in  1  hazard-unit stall of ID/EX
flush_in  in  1  hazard-unit flush of ID/EX
valid_e  out  1  registered bundle valid
reg_write_e  out  1  register write
mem_write_e  out  1  store
alu_src_e  out  1  ALU B = immediate
alu_a_pc_e  out  1  ALU A = PC (auipc)
branch_e  out  1  conditional branch
branch_type_e  out  3  = funct3 of branch
jump_e  out  2  00 none, 01 jal, 10 jalr
result_src_e  out  2  00 ALU, 01 mem, 10 PC+4, 11 CSR
imm_src_e  out  3  000 I, 001 S, 010 B, 011 J, 100 U
alu_ctrl_e  out  ALUCTRL_W  0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sltu,7 sll,8 srl,9 sra,10 passB
mdu_en_e  out  1  M-extension op
mdu_op_e  out  3  = funct3 of M-op
illegal_e  out  1  unrecognised encoding (valid_e also 1)
stall_req  out  1  MDU busy; front end must hold

Behaviour:
- Single clock clk; reset synchronous, active-high. On reset all outputs are 0, FSM goes to IDLE and the counter to 0.
- Decode is combinational. Decoded fields go to the *_e registers on accept (latency 1).
- Decode table:
  - 0000011 load: reg_write, alu_src, result 01, imm I, add.
  - 0100011 store: mem_write, alu_src, imm S, add.
  - 0110011 R: funct7=0000000 ALU by funct3 (000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and). funct7=0100000 only with funct3 000 (sub) or 101 (sra). funct7=0000001 sets mdu_en and mdu_op=funct3. All other R encodings are illegal.
  - 0010011 I-ALU: same map without sub. funct3 001 needs funct7=0. funct3 101 takes srl/sra from funct7.
  - 1100011 branch: sub, imm B. funct3 010/011 are illegal.
  - 1101111 jal: jump 01, result 10, imm J.
  - 1100111 jalr: jump 10, alu_src, result 10, imm I.
  - 0110111 lui: passB, alu_src, imm U.
  - 0010111 auipc: add, alu_a_pc, alu_src, imm U.
  - Anything else: illegal_e=1, all write/branch/jump controls 0.
- ID/EX register priority, in order:
  - reset.
  - flush_in: bubble, all *_e = 0.
  - stall_in or stall_req: hold.
  - Otherwise load. When instr_valid_d=0, load a bubble.
- FSM IDLE/BUSY:
  - IDLE -> BUSY when an MDU op is loaded. Counter loads MUL_CYCLES-1 (funct3[2]=0) or DIV_CYCLES-1 (funct3[2]=1).
  - In BUSY, stall_req=1 and the counter decrements each cycle. At count 0 go to IDLE; stall_req drops that same edge.
  - If the loaded count is 0 (CYCLES=1), stay IDLE; stall_req is never asserted.
  - stall_req is a registered, combinational function of state only; it is never driven from inputs.
  - flush_in while BUSY: abort to IDLE and clear the counter; the bundle is bubbled.
  - stall_in while BUSY: counter still decrements.
- A second MDU op can only load after stall_req drops, so ops never overlap.

Optional Feature:
CSR_DECODE_EN: when defined, op 1110011 with funct3 != 000 decodes as CSR: reg_write, result 11, imm I (zimm via funct3[2]), alu_ctrl passB. funct3=100 is illegal. funct3=000 (ecall/ebreak/mret) passes through with illegal_e=0 and no controls. When undefined, all 1110011 encodings are illegal.

Test Plan:
- Reset mid-MDU busy: div loaded, reset after 3 cycles -> next cycle stall_req=0, all *_e=0, the following add loads normally.
- Decode sweep: sub (0110011/000/0100000) -> alu_ctrl 1, reg_write 1. jalr -> jump 10, result 10, alu_src 1. funct7=0100000 with funct3 001 -> illegal_e 1, reg_write 0.
- Divide: div loaded, DIV_CYCLES=32 -> stall_req high exactly 31 cycles, *_e held. mul with MUL_CYCLES=2 -> stall_req high 1 cycle.
- Flush priority: flush_in=1 and stall_in=1 together with a valid load -> next cycle valid_e=0, all controls 0.
- Flush during busy: flush_in in cycle 5 of a div -> stall_req 0 next cycle, FSM IDLE, bubble in E.
- CSR: csrrw (1110011/001) -> with CSR_DECODE_EN, result 11 and reg_write 1; without it, illegal_e 1.
